// File: rtl/multi_down_timer_pkg.sv
// rtl/multi_down_timer_pkg.sv - shared state encoding and mode constants for the multi-channel timer
package multi_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/multi_down_timer_channel.sv
// rtl/multi_down_timer_channel.sv - one reloading down-counter channel with mode, state and pending flag
module timer_channel
    import multi_down_timer_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_mode,
    input  logic             i_restart,
    input  logic             i_en,
    input  logic             i_irq_clr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_done,
    output logic             o_pend
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_pend;
    logic [WIDTH-1:0] w_eff_reload;
    logic             w_at_zero;
    logic             w_tc;

    // A same-cycle write to this channel is forwarded into a restart.
    assign w_eff_reload = i_wr_en ? i_wr_data : r_reload;
    assign w_at_zero    = (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_restart) begin
            w_state_nxt = ST_RUN;
        end else if (w_tc && (r_mode == MODE_ONESHOT)) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_comb begin
        w_tc   = (r_state == ST_RUN) && i_en && w_at_zero;
        o_done = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reload <= '0;
            r_mode   <= MODE_PERIODIC;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_reload <= i_wr_data;
                r_mode   <= i_wr_mode;
            end
            if (i_restart) begin
                r_cnt <= w_eff_reload;
            end else if (w_tc) begin
                r_cnt <= (r_mode == MODE_ONESHOT) ? '0 : r_reload;
            end else if ((r_state == ST_RUN) && i_en) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_tc) begin
                r_pend <= 1'b1;
            end else if (i_irq_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tc   = w_tc;
    assign o_pend = r_pend;

endmodule

// File: rtl/multi_down_timer.sv
// rtl/multi_down_timer.sv - NCH independent reloading down-timers with shared write port and irq
module multi_down_timer
    import multi_down_timer_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int NCH   = 4,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [CHW-1:0]     i_wr_ch,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_wr_mode,
    input  logic [NCH-1:0]     i_restart,
    input  logic [NCH-1:0]     i_en,
    input  logic [NCH-1:0]     i_irq_clr,
    output logic [NCH*WIDTH-1:0] o_cnt,
    output logic [NCH-1:0]     o_tc,
    output logic [NCH-1:0]     o_done,
    output logic [NCH-1:0]     o_pend,
    output logic               o_irq
);

    logic [NCH-1:0] w_wr_sel;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Channel numbers at or above NCH never match, so such writes are dropped.
        assign w_wr_sel[g] = i_wr_en && (i_wr_ch == CHW'(g));

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (w_wr_sel[g]),
            .i_wr_data (i_wr_data),
            .i_wr_mode (i_wr_mode),
            .i_restart (i_restart[g]),
            .i_en      (i_en[g]),
            .i_irq_clr (i_irq_clr[g]),
            .o_cnt     (o_cnt[g*WIDTH +: WIDTH]),
            .o_tc      (o_tc[g]),
            .o_done    (o_done[g]),
            .o_pend    (o_pend[g])
        );
    end

    assign o_irq = |o_pend;

endmodule

// File: tb/tb_multi_down_timer.sv
// tb/tb_multi_down_timer.sv - scoreboard bench for multi_down_timer against a per-cycle reference model
module tb_multi_down_timer;

    localparam int W = 6;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [W-1:0]   wr_data = '0;
    logic           wr_mode = 1'b0;
    logic [N-1:0]   restart = '0;
    logic [N-1:0]   en = '0;
    logic [N-1:0]   irq_clr = '0;
    logic [N*W-1:0] cnt;
    logic [N-1:0]   tc, done, pend;
    logic           irq;

    multi_down_timer #(.WIDTH(W), .NCH(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
        .i_wr_data(wr_data), .i_wr_mode(wr_mode), .i_restart(restart),
        .i_en(en), .i_irq_clr(irq_clr), .o_cnt(cnt), .o_tc(tc),
        .o_done(done), .o_pend(pend), .o_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] cnt;
        logic [N-1:0]   tc;
        logic [N-1:0]   done;
        logic [N-1:0]   pend;
        logic           irq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: count value, whether counting, whether finished, stored registers.
    int m_cnt[N];
    bit m_run[N];
    bit m_done[N];
    bit m_pend[N];
    int m_reload[N];
    bit m_oneshot[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0;
            m_pend[i] = 0; m_reload[i] = 0; m_oneshot[i] = 0;
        end
    endtask

    task automatic tick();
        exp_t e;
        bit   t[N];
        bit   hit;
        e.irq = 1'b0;
        for (int i = 0; i < N; i++) begin
            t[i] = m_run[i] && en[i] && (m_cnt[i] == 0);
            e.cnt[i*W +: W] = W'(m_cnt[i]);
            e.tc[i]   = t[i];
            e.done[i] = m_done[i];
            e.pend[i] = m_pend[i];
            e.irq     = e.irq | m_pend[i];
        end
        q.push_back(e);
        for (int i = 0; i < N; i++) begin
            hit = wr_en && (int'(wr_ch) == i);
            if (restart[i]) begin
                m_cnt[i]  = hit ? int'(wr_data) : m_reload[i];
                m_run[i]  = 1;
                m_done[i] = 0;
            end else if (t[i]) begin
                if (m_oneshot[i]) begin
                    m_run[i] = 0; m_done[i] = 1; m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_reload[i];
                end
            end else if (m_run[i] && en[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
            if (t[i]) m_pend[i] = 1;
            else if (irq_clr[i]) m_pend[i] = 0;
            if (hit) begin
                m_reload[i]  = int'(wr_data);
                m_oneshot[i] = wr_mode;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; restart = '0; irq_clr = '0;
    endtask

    task automatic write(input int ch, input int val, input bit mode);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_data = W'(val); wr_mode = mode;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("cnt",  32'(cnt),  32'(e.cnt));
            chk("tc",   32'(tc),   32'(e.tc));
            chk("done", 32'(done), 32'(e.done));
            chk("pend", 32'(pend), 32'(e.pend));
            chk("irq",  32'(irq),  32'(e.irq));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cnt"},  32'(cnt),  32'd0);
        chk({tag, "_tc"},   32'(tc),   32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pend"}, 32'(pend), 32'd0);
        chk({tag, "_irq"},  32'(irq),  32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // ch0 periodic reload 3, with clears both away from and on a tc cycle
        write(0, 3, 1'b0); tick();
        restart[0] = 1'b1; en[0] = 1'b1; tick();
        ticks(9);
        for (int k = 0; k < 5; k++) begin irq_clr[0] = 1'b1; tick(); end

        // ch1 one-shot reload 2, then restart out of DONE
        write(1, 2, 1'b1); tick();
        restart[1] = 1'b1; en[1] = 1'b1; tick();
        ticks(6);
        restart[1] = 1'b1; tick();
        ticks(2);

        // ch2 write-through restart, then a write while running
        write(2, 5, 1'b0); restart[2] = 1'b1; en[2] = 1'b1; tick();
        ticks(2);
        write(2, 1, 1'b0); tick();
        ticks(8);

        // hold ch0 at count 1 for three disabled cycles
        for (int k = 0; k < 20 && m_cnt[0] != 1; k++) tick();
        chk("en_hold_reach", 32'(m_cnt[0]), 32'd1);
        en[0] = 1'b0; ticks(3);
        en[0] = 1'b1; ticks(3);

        // ch0 reload 0 periodic ticks every enabled cycle
        write(0, 0, 1'b0); restart[0] = 1'b1; tick();
        ticks(4);

        // out-of-range channel must not touch any channel
        write(3, 7, 1'b1); tick();
        ticks(6);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(3);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                write(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < N; i++) begin
                restart[i] = ($urandom_range(0, 15) == 0);
                en[i]      = ($urandom_range(0, 7) != 0);
                irq_clr[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_down_timer.md
# multi_down_timer

Parametrised, multi-channel successor to the team's single 6-bit reloading down-counter. Provides NCH independent WIDTH-bit down-counting timers, each with a software-written reload value, periodic or one-shot mode, per-channel count enable, terminal-count pulses and a sticky interrupt-pending flag. Sits between the register/bus logic (which drives the write port) and consumers that need periodic ticks or timeouts, such as display refresh, debounce or scheduling.

## Interface
- WIDTH, 6: counter and reload width in bits (≥2).
- NCH, 4: number of channels (≥1); CHW = max(1, $clog2(NCH)).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for reload/mode register of channel wr_ch.
- wr_ch  in  CHW  target channel; values ≥NCH are ignored.
- wr_data  in  WIDTH  new reload value.
- wr_mode  in  1  0 = periodic, 1 = one-shot.
- restart  in  NCH  per-channel start/restart strobe.
- en  in  NCH  per-channel count enable; counter holds while low.
- irq_clr  in  NCH  per-channel pending-flag clear.
- cnt  out  NCH*WIDTH  current count; channel i at [i*WIDTH +: WIDTH].
- tc  out  NCH  terminal-count pulse, combinational.
- done  out  NCH  one-shot finished (level).
- pend  out  NCH  sticky terminal-count flags.
- irq  out  1  OR of pend.

## Operation
- Per-channel state: IDLE, RUN, DONE (2 bits). Reset: state IDLE, cnt 0, reload 0, mode periodic, pend 0; therefore tc, done, irq all 0.
- Write: on wr_en with valid wr_ch, reload[wr_ch] <= wr_data and mode[wr_ch] <= wr_mode next edge. Does not change cnt or state; takes effect at the next reload or restart.
- restart[i] (highest priority, any state): cnt <= effective reload, state <= RUN. Effective reload = wr_data if same-cycle write targets channel i (write-through), else stored reload. Same rule for mode.
- IDLE: cnt holds; tc 0.
- RUN, en[i]=0: cnt and state hold; tc 0.
- RUN, en[i]=1, cnt != 0: cnt <= cnt - 1.
- RUN, en[i]=1, cnt == 0: tc[i]=1; periodic: cnt <= reload, stay RUN; one-shot: state <= DONE, cnt stays 0.
- DONE: done[i]=1, cnt 0, tc 0; leaves only on restart or reset.
- tc[i] = (state==RUN) & en[i] & (cnt==0).
- pend[i] <= 1 on tc[i]; else 0 on irq_clr[i]; set wins over simultaneous clear.
- Arithmetic is unsigned, WIDTH bits; decrement never executes at 0, so no wrap to all-ones.

## Timing
- restart at edge k with reload R, en held high: cnt = R after k, tc asserted in the cycle where cnt = 0, i.e. R cycles after k; periodic period = R+1 enabled cycles.
- Reload 0 periodic: tc high every enabled cycle.
- pend visible one cycle after tc; irq combinational from pend.
- en deasserted with cnt=0 in RUN: tc drops, count holds 0, tc reasserts when en returns.
- Reset asserted mid-count: all channels return immediately (asynchronously) to reset values; no tc or pend is generated.

## Structure
- Package multi_down_timer_pkg: state enum (IDLE, RUN, DONE), mode constants MODE_PERIODIC = 0 and MODE_ONESHOT = 1.
- Sub-module timer_channel (WIDTH): one channel's reload, mode and state registers, counter and pend flag. The top level holds only write-address decode, the generate loop, output packing and the irq OR.

## Test plan
- Reset, then write ch0 reload 3 periodic, restart ch0, en=1 -> cnt sequence 3,2,1,0,3,…; tc pulses every 4 cycles; pend set, irq=1; irq_clr -> pend 0 unless tc in same cycle.
- ch1 one-shot reload 2, restart -> cnt 2,1,0; single tc; done=1 and stays; restart -> RUN again, done 0.
- Same-cycle write (reload 5) and restart on ch2 -> cnt = 5 next cycle. Write while running -> current countdown unaffected; new value used after next tc.
- en toggled low at cnt=1 for 3 cycles -> cnt holds 1, no tc; resume gives tc one enabled cycle later. Reload 0 periodic -> tc every enabled cycle.
- Simultaneous tc and irq_clr -> pend stays 1. wr_ch ≥ NCH (NCH=3, wr_ch=3) -> no register changes.
- Assert rst asynchronously mid-count on all channels -> cnt, pend, done, irq = 0 before next edge; channels IDLE until restart.
